// File: rtl/general_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : general_control_unit
// Description : Fetch/decode/execute sequencer for the general microprocessor
//               datapath, with an Enter handshake and a retired-instruction
//               counter.
// Revision    : 1.0 - initial release
// ============================================================================
module general_control_unit #(
    parameter int CNT_W = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [2:0]       IR,
    input  logic             Aeq0,
    input  logic             Apos,
    input  logic             Enter,
    output logic             IRload,
    output logic             PCload,
    output logic             JMPmux,
    output logic             Meminst,
    output logic             MemWr,
    output logic             Aload,
    output logic             Sub,
    output logic [1:0]       Asel,
    output logic             Halted,
    output logic [3:0]       State,
    output logic [CNT_W-1:0] InstrCount
);

    typedef enum logic [3:0] {
        ST_START  = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_LOAD   = 4'd8,
        ST_STORE  = 4'd9,
        ST_ADD    = 4'd10,
        ST_SUB    = 4'd11,
        ST_INPUT  = 4'd12,
        ST_JZ     = 4'd13,
        ST_JPOS   = 4'd14,
        ST_HALT   = 4'd15
    } state_t;

    localparam logic [1:0] ASEL_ALU = 2'b00;
    localparam logic [1:0] ASEL_IN  = 2'b01;
    localparam logic [1:0] ASEL_MEM = 2'b10;

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   instr_count;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= ST_START;
        end else begin
            state <= next_state;
        end
    end

    // Counts on the edge that ends FETCH; natural wrap at all-ones.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            instr_count <= '0;
        end else if (state == ST_FETCH) begin
            instr_count <= instr_count + 1'b1;
        end
    end

    always_comb begin
        next_state = ST_START;
        IRload     = 1'b0;
        PCload     = 1'b0;
        JMPmux     = 1'b0;
        Meminst    = 1'b0;
        MemWr      = 1'b0;
        Aload      = 1'b0;
        Sub        = 1'b0;
        Asel       = ASEL_ALU;
        Halted     = 1'b0;
        case (state)
            ST_START: begin
                next_state = ST_FETCH;
            end
            ST_FETCH: begin
                IRload     = 1'b1;
                PCload     = 1'b1;
                next_state = ST_DECODE;
            end
            ST_DECODE: begin
                Meminst    = 1'b1;
                next_state = state_t'({1'b1, IR});
            end
            ST_LOAD: begin
                Meminst    = 1'b1;
                Asel       = ASEL_MEM;
                Aload      = 1'b1;
                next_state = ST_FETCH;
            end
            ST_STORE: begin
                Meminst    = 1'b1;
                MemWr      = 1'b1;
                next_state = ST_FETCH;
            end
            ST_ADD: begin
                Meminst    = 1'b1;
                Aload      = 1'b1;
                next_state = ST_FETCH;
            end
            ST_SUB: begin
                Meminst    = 1'b1;
                Sub        = 1'b1;
                Aload      = 1'b1;
                next_state = ST_FETCH;
            end
            ST_INPUT: begin
                // Aload follows Enter directly so data is captured with no wait cycle.
                Asel       = ASEL_IN;
                Aload      = Enter;
                next_state = Enter ? ST_FETCH : ST_INPUT;
            end
            ST_JZ: begin
                JMPmux     = 1'b1;
                PCload     = Aeq0;
                next_state = ST_FETCH;
            end
            ST_JPOS: begin
                JMPmux     = 1'b1;
                PCload     = Apos;
                next_state = ST_FETCH;
            end
            ST_HALT: begin
                Halted     = 1'b1;
                next_state = ST_HALT;
            end
            default: begin
                next_state = ST_START;
            end
        endcase
    end

    assign State      = state;
    assign InstrCount = instr_count;

endmodule
`default_nettype wire

// File: tb/tb_general_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_general_control_unit
// Description : Randomized scoreboard bench for general_control_unit; a second
//               instance with a 2-bit counter exercises counter wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_general_control_unit;

    typedef struct packed {
        logic [3:0] st;
        logic [6:0] strobes;   // {IRload,PCload,JMPmux,Meminst,MemWr,Aload,Sub}
        logic [1:0] asel;
        logic       halted;
        int         cnt;
    } exp_t;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [2:0]  IR    = 3'd0;
    logic        Aeq0  = 1'b0;
    logic        Apos  = 1'b0;
    logic        Enter = 1'b0;

    logic        IRload, PCload, JMPmux, Meminst, MemWr, Aload, Sub, Halted;
    logic [1:0]  Asel;
    logic [3:0]  State;
    logic [15:0] InstrCount;

    logic        w_irload, w_pcload, w_jmpmux, w_meminst, w_memwr, w_aload, w_sub, w_halted;
    logic [1:0]  w_asel;
    logic [3:0]  w_state;
    logic [1:0]  w_count;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   cnt      = 0;

    general_control_unit #(.CNT_W(16)) dut (
        .Clock(Clock), .Reset(Reset), .IR(IR), .Aeq0(Aeq0), .Apos(Apos), .Enter(Enter),
        .IRload(IRload), .PCload(PCload), .JMPmux(JMPmux), .Meminst(Meminst),
        .MemWr(MemWr), .Aload(Aload), .Sub(Sub), .Asel(Asel), .Halted(Halted),
        .State(State), .InstrCount(InstrCount)
    );

    general_control_unit #(.CNT_W(2)) dut_w2 (
        .Clock(Clock), .Reset(Reset), .IR(IR), .Aeq0(Aeq0), .Apos(Apos), .Enter(Enter),
        .IRload(w_irload), .PCload(w_pcload), .JMPmux(w_jmpmux), .Meminst(w_meminst),
        .MemWr(w_memwr), .Aload(w_aload), .Sub(w_sub), .Asel(w_asel), .Halted(w_halted),
        .State(w_state), .InstrCount(w_count)
    );

    always #5 Clock = ~Clock;

    function automatic logic rb();
        bit [31:0] r;
        r = $urandom;
        return r[0];
    endfunction

    function automatic exp_t mk(input logic [3:0] st, input logic [6:0] s,
                                input logic [1:0] a, input logic h);
        exp_t e;
        e.st = st; e.strobes = s; e.asel = a; e.halted = h; e.cnt = cnt;
        return e;
    endfunction

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s at %0t: actual=%0d expected=%0d", name, $time, act, expv);
        end
    endtask

    always @(negedge Clock) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check("state",   int'(State), int'(mon_e.st));
            check("strobes", int'({IRload, PCload, JMPmux, Meminst, MemWr, Aload, Sub}),
                  int'(mon_e.strobes));
            check("asel",    int'(Asel), int'(mon_e.asel));
            check("halted",  int'(Halted), int'(mon_e.halted));
            check("count16", int'(InstrCount), mon_e.cnt % 65536);
            check("count2",  int'(w_count), mon_e.cnt % 4);
        end
    end

    // One clock cycle: apply inputs, queue the expected observation for this cycle.
    task automatic drive(input logic rst, input logic [2:0] ir, input logic en,
                         input logic a0, input logic ap, input exp_t e);
        Reset = rst; IR = ir; Enter = en; Aeq0 = a0; Apos = ap;
        sb.push_back(e);
        @(posedge Clock);
        #1;
    endtask

    task automatic fetch_decode(input logic [2:0] op);
        drive(1'b0, op, rb(), rb(), rb(), mk(4'd1, 7'b1100000, 2'b00, 1'b0));
        cnt++;
        drive(1'b0, op, rb(), rb(), rb(), mk(4'd2, 7'b0001000, 2'b00, 1'b0));
    endtask

    task automatic execute(input logic [2:0] op, input int n_wait);
        logic a0, ap, en;
        a0 = rb(); ap = rb(); en = rb();
        case (op)
            3'd0: drive(1'b0, op, en, a0, ap, mk(4'd8,  7'b0001010, 2'b10, 1'b0));
            3'd1: drive(1'b0, op, en, a0, ap, mk(4'd9,  7'b0001100, 2'b00, 1'b0));
            3'd2: drive(1'b0, op, en, a0, ap, mk(4'd10, 7'b0001010, 2'b00, 1'b0));
            3'd3: drive(1'b0, op, en, a0, ap, mk(4'd11, 7'b0001011, 2'b00, 1'b0));
            3'd4: begin
                for (int k = 0; k < n_wait; k++)
                    drive(1'b0, op, 1'b0, rb(), rb(), mk(4'd12, 7'b0000000, 2'b01, 1'b0));
                drive(1'b0, op, 1'b1, a0, ap, mk(4'd12, 7'b0000010, 2'b01, 1'b0));
            end
            3'd5: drive(1'b0, op, en, a0, ap, mk(4'd13, {1'b0, a0, 1'b1, 4'b0000}, 2'b00, 1'b0));
            3'd6: drive(1'b0, op, en, a0, ap, mk(4'd14, {1'b0, ap, 1'b1, 4'b0000}, 2'b00, 1'b0));
            default: begin
                for (int k = 0; k < 20; k++)
                    drive(1'b0, 3'($urandom), rb(), rb(), rb(), mk(4'd15, 7'b0, 2'b00, 1'b1));
            end
        endcase
    endtask

    initial begin
        logic [2:0] plan [10];
        logic [2:0] op;
        int         nwait;
        int         kind;
        plan = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd5, 3'd6, 3'd4, 3'd0, 3'd0};

        @(posedge Clock);
        #1;
        for (int ep = 0; ep < 12; ep++) begin
            cnt = 0;
            drive(1'b1, 3'($urandom), rb(), rb(), rb(), mk(4'd0, 7'b0, 2'b00, 1'b0));
            drive(1'b0, 3'($urandom), rb(), rb(), rb(), mk(4'd0, 7'b0, 2'b00, 1'b0));
            if (ep == 0) begin
                for (int i = 0; i < 10; i++) begin
                    fetch_decode(plan[i]);
                    execute(plan[i], (plan[i] == 3'd4) ? 5 : 0);
                end
                kind = 0;
            end else begin
                for (int i = 0; i < int'($urandom_range(20, 6)); i++) begin
                    op    = 3'($urandom_range(6, 0));
                    nwait = (rb() == 1'b1) ? 0 : int'($urandom_range(6, 1));
                    fetch_decode(op);
                    execute(op, nwait);
                end
                kind = int'($urandom_range(2, 0));
            end

            case (kind)
                0: begin
                    fetch_decode(3'd7);
                    execute(3'd7, 0);
                    drive(1'b1, 3'($urandom), rb(), rb(), rb(), mk(4'd15, 7'b0, 2'b00, 1'b1));
                end
                1: begin
                    fetch_decode(3'd4);
                    for (int k = 0; k < int'($urandom_range(4, 0)); k++)
                        drive(1'b0, 3'd4, 1'b0, rb(), rb(), mk(4'd12, 7'b0000000, 2'b01, 1'b0));
                    op[0] = rb();
                    drive(1'b1, 3'd4, op[0], rb(), rb(),
                          mk(4'd12, {5'b00000, op[0], 1'b0}, 2'b01, 1'b0));
                end
                default: begin
                    drive(1'b1, 3'($urandom), rb(), rb(), rb(), mk(4'd1, 7'b1100000, 2'b00, 1'b0));
                end
            endcase
        end

        Reset = 1'b1;
        @(negedge Clock);
        @(negedge Clock);
        check("sb_drain", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/general_control_unit.md
# general_control_unit

Finite-state control unit that sequences the general microprocessor's datapath. It drives the datapath control strobes (IRload, PCload, JMPmux, Meminst, MemWr, Aload, Sub, Asel) and consumes the datapath status outputs (IR opcode, Aeq0, Apos). It runs the fetch–decode–execute cycle for the 3-bit instruction set and handles a single-bit Enter handshake for the INPUT instruction. It also keeps a retired-instruction counter for bring-up and verification.

## Interface
- CNT_W, 16, width of the retired-instruction counter
- Clock  input  1  system clock; all state changes on the rising edge
- Reset  input  1  synchronous, active-high; the FSM goes to START and the counter clears on the edge where Reset=1
- IR  input  3  opcode from the datapath instruction register
- Aeq0  input  1  accumulator equals zero
- Apos  input  1  accumulator is positive (bit 7 = 0 and nonzero)
- Enter  input  1  user-input valid; level, sampled only in INPUT
- IRload, PCload, JMPmux, Meminst, MemWr, Aload, Sub  output  1 each  datapath control strobes
- Asel  output  2  accumulator source: 00 = adder/subtractor, 01 = data_in, 10 = memory
- Halted  output  1  high while in HALT
- State  output  4  current state encoding (debug)
- InstrCount  output  CNT_W  instructions fetched since reset; wraps modulo 2^CNT_W

## Operation
- State encoding: START=0, FETCH=1, DECODE=2. Execute states use {1'b1, IR}: LOAD=8, STORE=9, ADD=10, SUB=11, INPUT=12, JZ=13, JPOS=14, HALT=15. Codes 3–7 are unused and go to START.
- Outputs are decoded from the state register. Any strobe not listed for a state is 0, and Asel defaults to 00.
- START: no strobes. Next state is FETCH.
- FETCH: IRload=1, PCload=1, JMPmux=0, Meminst=0. InstrCount increments. Next state is DECODE.
- DECODE: Meminst=1, so the operand address is presented early. Next state is {1'b1, IR}.
- LOAD: Meminst=1, Asel=10, Aload=1. Next state is FETCH.
- STORE: Meminst=1, MemWr=1. Next state is FETCH.
- ADD: Meminst=1, Asel=00, Sub=0, Aload=1. Next state is FETCH.
- SUB: Meminst=1, Asel=00, Sub=1, Aload=1. Next state is FETCH.
- INPUT: Asel=01, and Aload=Enter (the only Mealy output).
  - Enter=1: go to FETCH.
  - Enter=0: stay in INPUT.
- JZ: JMPmux=1, PCload=Aeq0. Next state is FETCH.
- JPOS: JMPmux=1, PCload=Apos. Next state is FETCH.
- HALT: Halted=1, no strobes. The state holds until Reset.
- Reset has priority over every transition, including mid-INPUT wait and HALT.

## Timing
- Reset values: State=0 (START), InstrCount=0, Halted=0, all strobes 0, Asel=00.
- The first FETCH is one cycle after Reset deasserts.
- Instruction latency is 3 cycles (FETCH, DECODE, EXEC) for all opcodes except:
  - INPUT takes 3 + n cycles, where n is the number of cycles Enter stays low after INPUT is entered.
  - HALT is terminal.
- The datapath samples IR at the edge ending FETCH, so IR is valid throughout DECODE and EXEC. The FSM uses IR only in DECODE.
- Aeq0 and Apos are sampled combinationally during JZ/JPOS. They reflect the accumulator value written by earlier instructions.
- If Enter=1 on the very first INPUT cycle, Aload is asserted in that cycle with no wait.
- InstrCount updates on the edge ending FETCH. At all-ones it wraps to 0.
- If Reset is asserted in the same cycle as FETCH, Reset wins: the count goes to 0, not 1.

## Test plan
- Reset release: hold Reset=1 for 2 cycles, then release. Expect State=0 with all outputs 0. Next cycle: State=1, IRload=1, PCload=1. Next: State=2, Meminst=1.
- LOAD/STORE/ADD/SUB: force IR=000, 001, 010, 011 in turn.
  - Expect state sequences 1→2→8, 1→2→9, 1→2→10, 1→2→11.
  - Execute-cycle outputs: LOAD has Asel=10, Aload=1. STORE has MemWr=1, Aload=0. SUB has Sub=1.
  - InstrCount=4 after the four fetches.
- Jumps: IR=101 with Aeq0=1 gives PCload=1, JMPmux=1 in state 13. IR=101 with Aeq0=0 gives PCload=0. IR=110 with Apos=1 gives PCload=1.
- INPUT wait: IR=100 with Enter=0 for 5 cycles, then 1.
  - State stays 12 for 5 cycles with Asel=01 and Aload=0.
  - On the sixth cycle Aload=1, then State=1.
- HALT and reset mid-operation: with IR=111, State reaches 15, Halted=1, and it stays there for 20 cycles with InstrCount frozen. Assert Reset during INPUT and during HALT; expect State=0 and InstrCount=0 on the next edge.
- Counter wrap: with CNT_W=2, run 5 LOAD instructions. InstrCount reads 1,2,3,0,1.
